// File: rtl/full_adder_fa_bit.sv
// rtl/full_adder_fa_bit.sv - single combinational full-adder lane (3:2 compressor cell)
module fa_bit (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    logic p;

    // Propagate term is shared by sum and carry so the carry path stays one AND-OR deep.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - WIDTH independent full-adder lanes with optional registered copy
module full_adder #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] ci,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] co,
    output logic [WIDTH-1:0] s_q,
    output logic [WIDTH-1:0] co_q,
    output logic             out_valid
);

    // Lanes never chain; ripple adders build carries from s/co outside this block.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        fa_bit u_fa_bit (s[i], co[i], a[i], b[i], ci[i]);
    end

    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q       <= '0;
                co_q      <= '0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    s_q  <= s;
                    co_q <= co;
                end
            end
        end
    end else begin : g_noreg
        assign s_q       = '0;
        assign co_q      = '0;
        assign out_valid = 1'b0;
    end

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed self-checking bench for full_adder
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;

    // Single-lane registered DUT
    logic [0:0] a = '0, b = '0, ci = '0;
    logic [0:0] s, co, s_q, co_q;
    logic       out_valid;

    // Four single-lane instances chained LSB first through s/co
    logic [3:0] ch_a = '0, ch_b = '0;
    logic       ch_ci = 1'b0;
    logic [3:0] ch_s, ch_co, ch_cin, ch_sq, ch_coq, ch_ov;

    // Four-lane instance
    logic [3:0] w_a = '0, w_b = '0, w_ci = '0;
    logic [3:0] w_s, w_co, w_sq, w_coq;
    logic       w_ov;

    // Unregistered-variant instance
    logic [0:0] n_s, n_co, n_sq, n_coq;
    logic       n_ov;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .ci(ci), .in_valid(in_valid),
        .s(s), .co(co), .s_q(s_q), .co_q(co_q), .out_valid(out_valid)
    );

    assign ch_cin = {ch_co[2:0], ch_ci};
    for (genvar i = 0; i < 4; i++) begin : g_chain
        full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_chain (
            .clk(clk), .rst_n(rst_n), .a(ch_a[i]), .b(ch_b[i]), .ci(ch_cin[i]),
            .in_valid(1'b0), .s(ch_s[i]), .co(ch_co[i]), .s_q(ch_sq[i]),
            .co_q(ch_coq[i]), .out_valid(ch_ov[i])
        );
    end

    full_adder #(.WIDTH(4), .REG_OUT(1'b1)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .a(w_a), .b(w_b), .ci(w_ci), .in_valid(in_valid),
        .s(w_s), .co(w_co), .s_q(w_sq), .co_q(w_coq), .out_valid(w_ov)
    );

    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) dut_noreg (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .ci(ci), .in_valid(in_valid),
        .s(n_s), .co(n_co), .s_q(n_sq), .co_q(n_coq), .out_valid(n_ov)
    );

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_s_tab;
        logic [7:0] exp_co_tab;
        logic [2:0] idx;
        exp_s_tab  = 8'b1001_0110;
        exp_co_tab = 8'b1110_1000;

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("reset_s_q", 5'(s_q), 5'd0);
        check("reset_co_q", 5'(co_q), 5'd0);
        check("reset_out_valid", 5'(out_valid), 5'd0);

        // Exhaustive single lane, table indexed by {a,b,ci}
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            {a, b, ci} = idx;
            #1;
            check($sformatf("exh_s_%0d", i), 5'(s), 5'(exp_s_tab[idx]));
            check($sformatf("exh_co_%0d", i), 5'(co), 5'(exp_co_tab[idx]));
        end

        // Ripple chain of four
        ch_a = 4'b0001; ch_b = 4'b0001; ch_ci = 1'b1; #1;
        check("chain1_sum", 5'(ch_s), 5'b00011);
        check("chain1_co", 5'(ch_co[3]), 5'd0);
        ch_a = 4'b0010; ch_b = 4'b0110; ch_ci = 1'b0; #1;
        check("chain2_sum", 5'(ch_s), 5'b01000);
        check("chain2_co", 5'(ch_co[3]), 5'd0);
        ch_a = 4'b1111; ch_b = 4'b0001; ch_ci = 1'b0; #1;
        check("chain3_sum", 5'(ch_s), 5'b00000);
        check("chain3_co", 5'(ch_co[3]), 5'd1);
        ch_a = 4'b0010; ch_b = 4'b0011; ch_ci = 1'b1; #1;
        check("chain4_sum", 5'(ch_s), 5'b00110);
        check("chain4_co", 5'(ch_co[3]), 5'd0);

        // Four independent lanes
        w_a = 4'b1010; w_b = 4'b0110; w_ci = 4'b0011; #1;
        check("w4_s", 5'(w_s), 5'b01111);
        check("w4_co", 5'(w_co), 5'b00010);

        // Unregistered variant: comb path live, registered outputs tied low
        a = 1'b1; b = 1'b1; ci = 1'b0; in_valid = 1'b1; #1;
        check("noreg_s", 5'(n_s), 5'd0);
        check("noreg_co", 5'(n_co), 5'd1);
        check("noreg_regs", {2'b00, n_sq, n_coq, n_ov}, 5'd0);

        // Registered capture, then hold
        @(negedge clk);
        rst_n = 1'b1; a = 1'b1; b = 1'b1; ci = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        check("cap_s_q", 5'(s_q), 5'd0);
        check("cap_co_q", 5'(co_q), 5'd1);
        check("cap_out_valid", 5'(out_valid), 5'd1);
        check("cap_w4_s_q", 5'(w_sq), 5'b01111);
        check("cap_w4_co_q", 5'(w_coq), 5'b00010);
        in_valid = 1'b0; a = 1'b0; b = 1'b0; ci = 1'b1;
        @(posedge clk); #1;
        check("hold_s_q", 5'(s_q), 5'd0);
        check("hold_co_q", 5'(co_q), 5'd1);
        check("hold_out_valid", 5'(out_valid), 5'd0);

        // Mid-cycle asynchronous reset with out_valid high
        a = 1'b1; b = 1'b1; ci = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_s_q", 5'(s_q), 5'd1);
        check("pre_rst_out_valid", 5'(out_valid), 5'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_s_q", 5'(s_q), 5'd0);
        check("async_co_q", 5'(co_q), 5'd0);
        check("async_out_valid", 5'(out_valid), 5'd0);
        check("async_s_track", 5'({co, s}), 5'b00011);
        a = 1'b0; #1;
        check("async_s_track2", 5'({co, s}), 5'b00010);

        // Reset released just ahead of the edge that sees in_valid=1
        @(negedge clk);
        a = 1'b1; b = 1'b0; ci = 1'b0; in_valid = 1'b1;
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_s_q", 5'(s_q), 5'd1);
        check("release_co_q", 5'(co_q), 5'd0);
        check("release_out_valid", 5'(out_valid), 5'd1);
        check("release_w4_s_q", 5'(w_sq), 5'b01111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
